// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: retires one multiplier bit per
// clock, LSB first, shifting the {A, Q} partial product right.
module shift_add_multiplier #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state, next_state;
    logic [WIDTH-1:0]   m_r;
    logic [WIDTH:0]     a;
    logic [WIDTH-1:0]   q_r;
    logic [CW-1:0]      cnt;

    logic               accept;
    logic               last_step;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   shifted;

    assign accept    = start && (state == IDLE || state == DONE);
    assign last_step = (state == RUN) && (cnt == CW'(WIDTH - 1));

    // sum is WIDTH+1 wide so the carry survives into A[WIDTH] before the shift
    always_comb begin
        sum     = a + (q_r[0] ? {1'b0, m_r} : '0);
        shifted = {sum, q_r} >> 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_step) next_state = DONE;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_r     <= '0;
            a       <= '0;
            q_r     <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            m_r <= multiplicand;
            q_r <= multiplier;
            a   <= '0;
            cnt <= '0;
        end else if (state == RUN) begin
            a   <= shifted[2*WIDTH:WIDTH];
            q_r <= shifted[WIDTH-1:0];
            cnt <= cnt + 1'b1;
            if (last_step) begin
                product <= shifted[2*WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed cases from the
// operation rules plus randomized operands against a plain a*b reference.
module tb_shift_add_multiplier;

    localparam int unsigned WIDTH = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic [WIDTH-1:0]     mc = '0;
    logic [WIDTH-1:0]     mp = '0;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    int n_checks = 0;
    int n_pass   = 0;
    logic [2*WIDTH-1:0] exp_product = '0;

    shift_add_multiplier #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (mc),
        .multiplier   (mp),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return (2*WIDTH)'(x) * (2*WIDTH)'(y);
    endfunction

    // Called just after an edge with the DUT in IDLE or DONE. Asserts start for
    // the accept edge, optionally re-pulses start at steps g1/g2 with junk
    // operands, and checks the full busy/done/product timeline up to DONE.
    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input int g1, input int g2);
        logic [2*WIDTH-1:0] prev;
        prev  = exp_product;
        start = 1'b1;
        mc    = x;
        mp    = y;
        @(posedge clk); #1;
        start = 1'b0;
        mc    = WIDTH'($urandom);
        mp    = WIDTH'($urandom);
        check_eq("busy_after_accept", {62'd0, busy, done}, 64'h2);
        for (int step = 1; step <= int'(WIDTH); step++) begin
            if (step == g1 || step == g2) begin
                start = 1'b1;
                mc    = WIDTH'($urandom);
                mp    = WIDTH'($urandom);
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (step < int'(WIDTH)) begin
                check_eq("run_busy_done", {62'd0, busy, done}, 64'h2);
                check_eq("product_hold_run", 64'(product), 64'(prev));
            end else begin
                exp_product = ref_mul(x, y);
                check_eq("done_pulse", {62'd0, busy, done}, 64'h1);
                check_eq("product", 64'(product), 64'(exp_product));
            end
        end
    endtask

    // One idle cycle after DONE: pulse drops and product holds.
    task automatic idle_check();
        @(posedge clk); #1;
        check_eq("done_drop", {62'd0, busy, done}, 64'h0);
        check_eq("product_hold_idle", 64'(product), 64'(exp_product));
    endtask

    initial begin
        bit saw_done;
        logic [WIDTH-1:0] rx, ry;

        #2 rst = 1'b1;
        #1;
        check_eq("reset_outputs", {busy, done, 32'(product)}, 64'h0);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("idle_after_reset", {busy, done, 32'(product)}, 64'h0);

        // 3 x 5
        run_op(16'd3, 16'd5, 0, 0);
        check_eq("prod_3x5", 64'(product), 64'h0000000F);
        idle_check();

        // carry path
        run_op(16'hFFFF, 16'hFFFF, 0, 0);
        check_eq("prod_max", 64'(product), 64'hFFFE0001);
        idle_check();

        run_op(16'h0000, 16'hABCD, 0, 0);
        check_eq("prod_zero", 64'(product), 64'h0);
        idle_check();
        run_op(16'h1234, 16'h0001, 0, 0);
        check_eq("prod_ident", 64'(product), 64'h00001234);
        idle_check();

        // start re-pulsed mid-run is ignored
        run_op(16'd7, 16'd9, 3, 10);
        check_eq("prod_ignore_start", 64'(product), 64'h3F);
        idle_check();

        // back-to-back: second start issued during the DONE cycle
        run_op(16'd7, 16'd9, 0, 0);
        check_eq("prod_b2b_first", 64'(product), 64'h3F);
        run_op(16'h0100, 16'h0100, 0, 0);
        check_eq("prod_b2b_second", 64'(product), 64'h00010000);
        idle_check();

        // asynchronous reset mid-run
        start = 1'b1;
        mc    = 16'h00FF;
        mp    = 16'h00FF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("async_reset", {busy, done, 32'(product)}, 64'h0);
        @(posedge clk); #3;
        rst = 1'b0;
        exp_product = '0;
        saw_done = 1'b0;
        for (int i = 0; i < int'(WIDTH) + 4; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        check_eq("no_done_after_abort", {63'd0, saw_done}, 64'h0);
        run_op(16'h00FF, 16'h00FF, 0, 0);
        check_eq("prod_after_reset", 64'(product), 64'h0000FE01);
        idle_check();

        // randomized operands, random mid-run start pulses, random chaining
        for (int n = 0; n < 12; n++) begin
            rx = WIDTH'($urandom);
            ry = WIDTH'($urandom);
            if (n == 0) rx = 16'hFFFF;
            run_op(rx, ry, int'($urandom_range(0, WIDTH - 1)), int'($urandom_range(0, WIDTH - 1)));
            if ($urandom_range(0, 1) == 0) idle_check();
        end
        idle_check();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
